// File: rtl/mhd_pkg.sv
// Shared types for the Hamming-distance checker: controller state encoding and
// the distance-width helper. No logic, no latency, no flow control.
package mhd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Bits needed to hold a distance in 0..width inclusive.
    function automatic int hd_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/mhd_popcount.sv
// Hamming distance of one operand pair, popcount(a ^ b).
// Purely combinational, zero latency, no flow control.
module mhd_popcount
    import mhd_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int HD_W  = hd_width(WIDTH)
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [HD_W-1:0]  hd
);

    logic [WIDTH-1:0] diff;

    assign diff = a ^ b;

    always_comb begin
        hd = '0;
        for (int i = 0; i < WIDTH; i++) begin
            hd = hd + HD_W'(diff[i]);
        end
    end

endmodule

// File: rtl/mhd_check_ctrl.sv
// Run controller: counts pairs whose Hamming distance exceeds a threshold, tracks the max.
// done rises two edges after the last acceptance; in_ready only in RUN, in_valid gaps stall.
module mhd_check_ctrl
    import mhd_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int MHD   = 4,
    parameter  int CNT_W = 16,
    localparam int HD_W  = hd_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] cfg_n,
    input  logic [HD_W-1:0]  cfg_thr,
    input  logic             cfg_thr_en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             fail,
    output logic [CNT_W-1:0] err_cnt,
    output logic [HD_W-1:0]  max_hd
);

    localparam logic [HD_W-1:0] MHD_THR = HD_W'(MHD);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [HD_W-1:0]  thr_q, thr_d;
    logic [HD_W-1:0]  hd_q, hd_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [HD_W-1:0]  max_hd_q, max_hd_d;
    logic             fail_q, fail_d;

    logic [HD_W-1:0]  hd_c;
    logic             start_acc;
    logic             accept;

    mhd_popcount #(
        .WIDTH (WIDTH)
    ) u_popcount (
        .a  (a),
        .b  (b),
        .hd (hd_c)
    );

    // start only counts while the controller is not already processing a run.
    assign start_acc = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign accept    = in_valid && (state_q == ST_RUN);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = (cfg_n == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (accept && (rem_q == CNT_W'(1))) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: state_d = ST_DONE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        in_ready = (state_q == ST_RUN);
        busy     = (state_q == ST_RUN) || (state_q == ST_DRAIN);
        done     = (state_q == ST_DONE);
    end

    // Datapath: one stage of distance, then stats fold on the following edge.
    always_comb begin
        rem_d     = rem_q;
        thr_d     = thr_q;
        hd_d      = hd_q;
        valid_d   = accept;
        err_cnt_d = err_cnt_q;
        max_hd_d  = max_hd_q;
        fail_d    = fail_q;
        if (start_acc) begin
            rem_d     = cfg_n;
            thr_d     = cfg_thr_en ? cfg_thr : MHD_THR;
            err_cnt_d = '0;
            max_hd_d  = '0;
            fail_d    = 1'b0;
        end else begin
            if (accept) begin
                rem_d = rem_q - CNT_W'(1);
                hd_d  = hd_c;
            end
            if (valid_q) begin
                if (hd_q > thr_q) begin
                    err_cnt_d = err_cnt_q + CNT_W'(1);
                    fail_d    = 1'b1;
                end
                if (hd_q > max_hd_q) begin
                    max_hd_d = hd_q;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q     <= '0;
            thr_q     <= '0;
            hd_q      <= '0;
            valid_q   <= 1'b0;
            err_cnt_q <= '0;
            max_hd_q  <= '0;
            fail_q    <= 1'b0;
        end else begin
            rem_q     <= rem_d;
            thr_q     <= thr_d;
            hd_q      <= hd_d;
            valid_q   <= valid_d;
            err_cnt_q <= err_cnt_d;
            max_hd_q  <= max_hd_d;
            fail_q    <= fail_d;
        end
    end

    assign err_cnt = err_cnt_q;
    assign max_hd  = max_hd_q;
    assign fail    = fail_q;

endmodule

// File: tb/tb_mhd_check_ctrl.sv
// Directed-vector bench for mhd_check_ctrl with default parameters (WIDTH=8, MHD=4, CNT_W=16).
// Inputs change 1ns after the rising edge; outputs are compared in that same window.
module tb_mhd_check_ctrl;

    localparam int WIDTH = 8;
    localparam int CNT_W = 16;
    localparam int HD_W  = 4;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [CNT_W-1:0] cfg_n;
    logic [HD_W-1:0]  cfg_thr;
    logic             cfg_thr_en;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             fail;
    logic [CNT_W-1:0] err_cnt;
    logic [HD_W-1:0]  max_hd;

    int n_vec;
    int n_miss;

    mhd_check_ctrl #(
        .WIDTH (WIDTH),
        .MHD   (4),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .cfg_n      (cfg_n),
        .cfg_thr    (cfg_thr),
        .cfg_thr_en (cfg_thr_en),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .fail       (fail),
        .err_cnt    (err_cnt),
        .max_hd     (max_hd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int n, input int thr, input logic en);
        start      = 1'b1;
        cfg_n      = CNT_W'(n);
        cfg_thr    = HD_W'(thr);
        cfg_thr_en = en;
        tick();
        start      = 1'b0;
    endtask

    // Offer a pair and hold it until it is taken; in_valid stays high afterwards.
    task automatic send_pair(input logic [WIDTH-1:0] pa, input logic [WIDTH-1:0] pb);
        bit taken;
        taken    = 1'b0;
        in_valid = 1'b1;
        a        = pa;
        b        = pb;
        for (int k = 0; k < 20 && !taken; k++) begin
            if (in_ready) taken = 1'b1;
            tick();
        end
        if (!taken) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic chk_stats(input string tag, input int e, input int m, input logic f);
        chk({tag, "_err"},  32'(err_cnt), 32'(e));
        chk({tag, "_max"},  32'(max_hd),  32'(m));
        chk({tag, "_fail"}, 32'(fail),    32'(f));
    endtask

    initial begin
        n_vec      = 0;
        n_miss     = 0;
        rst_n      = 1'b1;
        start      = 1'b0;
        cfg_n      = '0;
        cfg_thr    = '0;
        cfg_thr_en = 1'b0;
        in_valid   = 1'b0;
        a          = '0;
        b          = '0;
        #2 rst_n = 1'b0;
        #2;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_rdy",  32'(in_ready), 0);
        chk_stats("rst", 0, 0, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        chk("idle_hold", 32'(busy | done), 0);

        // Three pairs, in_valid held, threshold MHD=4: hd 8,1,8.
        do_start(3, 0, 1'b0);
        chk("s1_rdy", 32'(in_ready), 1);
        send_pair(8'h00, 8'hFF);
        send_pair(8'h0F, 8'h0E);
        send_pair(8'hAA, 8'h55);
        in_valid = 1'b0;
        chk("s1_drain_busy", 32'(busy), 1);
        chk("s1_drain_done", 32'(done), 0);
        chk("s1_drain_rdy",  32'(in_ready), 0);
        tick();
        chk("s1_done", 32'(done), 1);
        chk("s1_busy", 32'(busy), 0);
        chk_stats("s1", 2, 8, 1'b1);

        // Restart straight from DONE with threshold 0: hd 0 then 1.
        do_start(2, 0, 1'b1);
        chk("s2_busy", 32'(busy), 1);
        chk("s2_rdy",  32'(in_ready), 1);
        chk_stats("s2_clr", 0, 0, 1'b0);
        send_pair(8'h12, 8'h12);
        send_pair(8'h12, 8'h13);
        in_valid = 1'b0;
        tick();
        chk("s2_done", 32'(done), 1);
        chk_stats("s2", 1, 1, 1'b1);

        // Empty run goes straight to DONE.
        do_start(0, 0, 1'b0);
        chk("s3_done", 32'(done), 1);
        chk("s3_rdy",  32'(in_ready), 0);
        chk_stats("s3", 0, 0, 1'b0);

        // Gapped in_valid with a stray start mid-run: hd 8,8,1,5 against MHD=4.
        do_start(4, 0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b0;
            if (k == 1) begin
                start      = 1'b1;
                cfg_n      = CNT_W'(9);
                cfg_thr    = HD_W'(15);
                cfg_thr_en = 1'b1;
            end
            tick();
            start = 1'b0;
            case (k)
                0: send_pair(8'hFF, 8'h00);
                1: send_pair(8'hF0, 8'h0F);
                2: send_pair(8'h01, 8'h03);
                default: send_pair(8'h1F, 8'h00);
            endcase
        end
        chk("s4_drain", 32'(busy), 1);
        tick();
        chk("s4_done", 32'(done), 1);
        chk_stats("s4", 3, 8, 1'b1);
        a = 8'h00;
        b = 8'hFF;
        tick();
        tick();
        in_valid = 1'b0;
        chk("s4_hold_done", 32'(done), 1);
        chk_stats("s4_hold", 3, 8, 1'b1);

        // Threshold equal to WIDTH never flags.
        do_start(1, 8, 1'b1);
        send_pair(8'h00, 8'hFF);
        in_valid = 1'b0;
        tick();
        chk("s6_done", 32'(done), 1);
        chk_stats("s6", 0, 8, 1'b0);

        // Reset after 2 of 5 accepts, then a fresh one-pair run.
        do_start(5, 0, 1'b0);
        send_pair(8'hFF, 8'h00);
        send_pair(8'hFF, 8'h00);
        in_valid = 1'b0;
        tick();
        chk_stats("s5_part", 2, 8, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("s5_rst_busy", 32'(busy), 0);
        chk("s5_rst_done", 32'(done), 0);
        chk("s5_rst_rdy",  32'(in_ready), 0);
        chk_stats("s5_rst", 0, 0, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        in_valid = 1'b1;
        tick();
        tick();
        in_valid = 1'b0;
        chk("s5_idle", 32'({busy, done, in_ready}), 0);
        chk_stats("s5_idle", 0, 0, 1'b0);
        do_start(1, 0, 1'b0);
        send_pair(8'h00, 8'h1F);
        in_valid = 1'b0;
        tick();
        chk("s5_done", 32'(done), 1);
        chk_stats("s5", 1, 5, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/mhd_check_ctrl.md
MHD_CHECK_CTRL -- requirements
Module: mhd_check_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning operand width in bits.
REQ-002 The block SHALL have parameter MHD, default 4, meaning the threshold used when cfg_thr_en=0.
REQ-003 The block SHALL have parameter CNT_W, default 16, meaning the width of the sample and error counters.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 start  input  1  one-cycle pulse that begins a check run.
REQ-007 cfg_n  input  CNT_W  number of (a,b) pairs in the run; sampled on start.
REQ-008 cfg_thr  input  HD_W  run-time threshold; sampled on start when cfg_thr_en=1.
REQ-009 cfg_thr_en  input  1  selects cfg_thr (1) or MHD (0); sampled on start.
REQ-010 in_valid  input  1  pair a,b is valid.
REQ-011 in_ready  output  1  block accepts a pair this cycle.
REQ-012 a, b  input  WIDTH each  operand pair under comparison.
REQ-013 busy  output  1  run in progress (states RUN or DRAIN).
REQ-014 done  output  1  level; results are valid (state DONE).
REQ-015 fail  output  1  at least one pair in the run had Hamming distance > threshold.
REQ-016 err_cnt  output  CNT_W  number of pairs with distance > threshold.
REQ-017 max_hd  output  HD_W  largest distance seen in the run; HD_W = clog2(WIDTH+1).

Function
REQ-018 The FSM SHALL have states IDLE, RUN, DRAIN, and DONE.
REQ-019 IDLE SHALL move to RUN on start with cfg_n>0, and to DONE on start with cfg_n=0 (stats zero).
REQ-020 On start, the block SHALL latch cfg_n and the threshold, and clear err_cnt, max_hd, and fail.
REQ-021 in_ready SHALL equal 1 only in RUN, and a pair SHALL be accepted when in_valid and in_ready are both 1.
REQ-022 Each accepted pair SHALL have its distance hd = popcount(a XOR b) registered into stage register hd_q with valid_q on the same edge.
REQ-023 On the edge after valid_q=1: err_cnt SHALL increment iff hd_q > threshold (strict), fail SHALL be set with it, and max_hd SHALL take max(max_hd, hd_q).
REQ-024 A remaining-count register SHALL decrement per accepted pair, and the acceptance that brings it to 0 SHALL move RUN to DRAIN.
REQ-025 DRAIN SHALL last exactly one cycle, during which the last stats update completes, and then move to DONE.
REQ-026 Latency SHALL be two edges from the acceptance of the last pair to done=1, with stats final when done rises.
REQ-027 DONE SHALL hold done=1 and the stats stable until the next start, which restarts per REQ-019/020 in the same cycle.
REQ-028 start SHALL be ignored in RUN and DRAIN, and the configuration SHALL remain unchanged.
REQ-029 in_valid gaps SHALL stall the run without a timeout, and pairs offered in other states SHALL be ignored.
REQ-030 Arithmetic SHALL be unsigned, and err_cnt cannot exceed cfg_n, so no saturation is needed.
REQ-031 A threshold >= WIDTH SHALL never flag a pair, and threshold 0 SHALL flag every pair with hd >= 1.

Reset
REQ-032 rst_n=0 SHALL asynchronously force IDLE, with busy, done, fail, in_ready, valid_q, err_cnt, max_hd, hd_q, and the remaining-count all 0.
REQ-033 A reset mid-run SHALL abandon the run with no partial results retained, and the block SHALL need a fresh start after release.
REQ-034 Reset release SHALL be synchronised externally, and the block SHALL leave IDLE only on start.

Structure
REQ-035 Shared package mhd_pkg SHALL hold the FSM state enum and a function computing HD_W from WIDTH.
REQ-036 Sub-module mhd_popcount (combinational, WIDTH in, HD_W out) SHALL compute popcount(a XOR b), with the controller owning all registers.

Verification
REQ-037 Scenario: cfg_n=3, MHD=4, pairs (00,FF) (0F,0E) (AA,55) with in_valid held -> err_cnt=2, max_hd=8, fail=1, done two edges after the third acceptance.
REQ-038 Scenario: cfg_thr_en=1, cfg_thr=0, cfg_n=2, pairs (12,12) (12,13) -> err_cnt=1, max_hd=1, fail=1.
REQ-039 Scenario: start with cfg_n=0 -> DONE the next cycle, in_ready never 1, err_cnt=0, fail=0.
REQ-040 Scenario: cfg_n=4 with in_valid toggling every other cycle, plus start pulsed during RUN -> exactly 4 accepts, start ignored, correct stats.
REQ-041 Scenario: rst_n low after 2 of 5 accepts -> all outputs 0 immediately; a new start with cfg_n=1, pair (00,1F) -> err_cnt=1, max_hd=5.
REQ-042 Scenario: start in DONE -> stats clear the next cycle and a new run begins with no idle cycle.
